ibus_dbus_mem_arbiter: RTL and testbench

- Shares one unified single-port memory between the VexRiscv simple iBus and dBus so instructions and data live in one address space.
- Accepts one command at a time from either bus and round-robins when both request in the same cycle.
- Drives a request/acknowledge memory port and returns the response on the issuing bus.
- Aborts with an error if the memory does not acknowledge within a timeout.

---
 rtl/ibus_dbus_mem_arbiter_if.sv | 49 ++++
 rtl/ibus_dbus_mem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_ibus_dbus_mem_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ibus_dbus_mem_arbiter_if.sv
// Bundle of the VexRiscv simple iBus/dBus ports and the request/acknowledge memory port.
// The slave modport is the arbiter's view; the master modport is the CPU and memory side.
interface ibus_dbus_mem_arbiter_if;
    logic        iBus_cmd_valid;
    logic        iBus_cmd_ready;
    logic [31:0] iBus_cmd_payload_pc;
    logic        iBus_rsp_valid;
    logic        iBus_rsp_payload_error;
    logic [31:0] iBus_rsp_payload_inst;

    logic        dBus_cmd_valid;
    logic        dBus_cmd_ready;
    logic        dBus_cmd_payload_wr;
    logic [31:0] dBus_cmd_payload_address;
    logic [31:0] dBus_cmd_payload_data;
    logic [1:0]  dBus_cmd_payload_size;
    logic        dBus_rsp_ready;
    logic        dBus_rsp_error;
    logic [31:0] dBus_rsp_data;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_err;

    modport slave (
        input  iBus_cmd_valid, iBus_cmd_payload_pc,
        output iBus_cmd_ready, iBus_rsp_valid, iBus_rsp_payload_error, iBus_rsp_payload_inst,
        input  dBus_cmd_valid, dBus_cmd_payload_wr, dBus_cmd_payload_address,
        input  dBus_cmd_payload_data, dBus_cmd_payload_size,
        output dBus_cmd_ready, dBus_rsp_ready, dBus_rsp_error, dBus_rsp_data,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  mem_ack, mem_rdata, mem_err
    );

    modport master (
        output iBus_cmd_valid, iBus_cmd_payload_pc,
        input  iBus_cmd_ready, iBus_rsp_valid, iBus_rsp_payload_error, iBus_rsp_payload_inst,
        output dBus_cmd_valid, dBus_cmd_payload_wr, dBus_cmd_payload_address,
        output dBus_cmd_payload_data, dBus_cmd_payload_size,
        input  dBus_cmd_ready, dBus_rsp_ready, dBus_rsp_error, dBus_rsp_data,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        output mem_ack, mem_rdata, mem_err
    );
endinterface

// File: rtl/ibus_dbus_mem_arbiter.sv
// Round-robin arbiter sharing one request/acknowledge memory between the iBus and dBus,
// one transaction in flight, with an optional acknowledge timeout that returns an error.
module ibus_dbus_mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    ibus_dbus_mem_arbiter_if.slave        bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    localparam bit               TIMEOUT_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    function automatic logic [3:0] laneMask(input logic [1:0] size, input logic [1:0] lowAddr);
        case (size)
            2'd0:    return 4'b0001 << lowAddr;
            2'd1:    return 4'b0011 << {lowAddr[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] lowAddr);
        case (size)
            2'd0:    return 1'b0;
            2'd1:    return lowAddr[0];
            2'd2:    return lowAddr != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    state_t           state;
    grant_t           lastGrant;
    logic [CNT_W-1:0] cnt;
    logic             ownerIsD;
    logic             ownerWr;

    logic             grantI;
    logic             grantD;
    logic [3:0]       dMask;
    logic             dBad;
    logic [CNT_W-1:0] cntNext;
    logic             timeoutHit;
    logic             finish;

    // Grant is only offered in IDLE and never while reset is held.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        grantI = 1'b0;
        grantD = 1'b0;
        if (state == IDLE && !reset) begin
            if (bus.iBus_cmd_valid && bus.dBus_cmd_valid) begin
                grantI = (lastGrant == GRANT_D);
                grantD = (lastGrant == GRANT_I);
            end else begin
                grantI = bus.iBus_cmd_valid;
                grantD = bus.dBus_cmd_valid;
            end
        end
    end

    assign bus.iBus_cmd_ready = grantI;
    assign bus.dBus_cmd_ready = grantD;

    assign dMask      = laneMask(bus.dBus_cmd_payload_size, bus.dBus_cmd_payload_address[1:0]);
    assign dBad       = isMisaligned(bus.dBus_cmd_payload_size, bus.dBus_cmd_payload_address[1:0]);
    assign cntNext    = cnt + CNT_W'(1);
    // An ack arriving on the limit cycle takes priority, so the timeout only fires without one.
    assign timeoutHit = TIMEOUT_EN && (cntNext == TIMEOUT_LIMIT);
    assign finish     = (state == BUSY) && (bus.mem_ack || timeoutHit);

    always_ff @(posedge clk) begin
        if (reset) begin
            state                      <= IDLE;
            lastGrant                  <= GRANT_D;
            cnt                        <= '0;
            ownerIsD                   <= 1'b0;
            ownerWr                    <= 1'b0;
            bus.mem_req                <= 1'b0;
            bus.mem_we                 <= 1'b0;
            bus.mem_addr               <= '0;
            bus.mem_wdata              <= '0;
            bus.mem_wmask              <= '0;
            bus.iBus_rsp_valid         <= 1'b0;
            bus.iBus_rsp_payload_error <= 1'b0;
            bus.dBus_rsp_ready         <= 1'b0;
            bus.dBus_rsp_error         <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples the pre-edge values of the others.
            bus.iBus_rsp_valid <= 1'b0;
            bus.dBus_rsp_ready <= 1'b0;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (grantI) begin
                        lastGrant     <= GRANT_I;
                        ownerIsD      <= 1'b0;
                        ownerWr       <= 1'b0;
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= 1'b0;
                        bus.mem_addr  <= {bus.iBus_cmd_payload_pc[31:2], 2'b00};
                        bus.mem_wmask <= 4'b1111;
                        state         <= BUSY;
                    end else if (grantD) begin
                        lastGrant <= GRANT_D;
                        ownerIsD  <= 1'b1;
                        ownerWr   <= bus.dBus_cmd_payload_wr;
                        if (dBad) begin
                            // Misaligned loads answer with an error; misaligned stores vanish.
                            if (!bus.dBus_cmd_payload_wr) begin
                                bus.dBus_rsp_ready <= 1'b1;
                                bus.dBus_rsp_error <= 1'b1;
                                state              <= RESP;
                            end
                        end else begin
                            bus.mem_req   <= 1'b1;
                            bus.mem_we    <= bus.dBus_cmd_payload_wr;
                            bus.mem_addr  <= {bus.dBus_cmd_payload_address[31:2], 2'b00};
                            bus.mem_wdata <= bus.dBus_cmd_payload_data;
                            bus.mem_wmask <= dMask;
                            state         <= BUSY;
                        end
                    end
                end

                BUSY: begin
                    if (finish) begin
                        bus.mem_req <= 1'b0;
                        bus.mem_we  <= 1'b0;
                        state       <= RESP;
                        if (!ownerIsD) begin
                            bus.iBus_rsp_valid         <= 1'b1;
                            bus.iBus_rsp_payload_error <= bus.mem_ack ? bus.mem_err : 1'b1;
                        end else if (!ownerWr) begin
                            bus.dBus_rsp_ready <= 1'b1;
                            bus.dBus_rsp_error <= bus.mem_ack ? bus.mem_err : 1'b1;
                        end
                    end else if (TIMEOUT_EN) begin
                        cnt <= cntNext;
                    end
                end

                RESP: state <= IDLE;

                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the wide read-data payload registers carry no reset; the response pulses qualify them.
    always_ff @(posedge clk) begin
        if (!reset && state == BUSY && bus.mem_ack) begin
            if (!ownerIsD) begin
                bus.iBus_rsp_payload_inst <= bus.mem_rdata;
            end else if (!ownerWr) begin
                bus.dBus_rsp_data <= bus.mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_ibus_dbus_mem_arbiter.sv
// Directed bench for ibus_dbus_mem_arbiter built with a 4-cycle acknowledge timeout.
module tb_ibus_dbus_mem_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   compared   = 0;
    int   mismatched = 0;

    ibus_dbus_mem_arbiter_if bus ();

    ibus_dbus_mem_arbiter #(
        .TIMEOUT_CYCLES(4),
        .CNT_W         (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Both buses request; the expected winner is served by a one-cycle ack.
    task automatic conflictRound(input bit expectD, input logic [31:0] rdata, input string tag);
        settle();
        check($sformatf("%s iReady", tag), bus.iBus_cmd_ready, !expectD);
        check($sformatf("%s dReady", tag), bus.dBus_cmd_ready, expectD);
        step();
        check($sformatf("%s busy iReady", tag), bus.iBus_cmd_ready, 0);
        check($sformatf("%s busy dReady", tag), bus.dBus_cmd_ready, 0);
        check($sformatf("%s mem_req", tag), bus.mem_req, 1);
        check($sformatf("%s mem_addr", tag), bus.mem_addr, expectD ? 32'h20 : 32'h10);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rdata;
        step();
        bus.mem_ack = 1'b0;
        check($sformatf("%s resp iReady", tag), bus.iBus_cmd_ready, 0);
        check($sformatf("%s resp dReady", tag), bus.dBus_cmd_ready, 0);
        check($sformatf("%s iRsp", tag), bus.iBus_rsp_valid, !expectD);
        check($sformatf("%s dRsp", tag), bus.dBus_rsp_ready, expectD);
        check($sformatf("%s rdata", tag), expectD ? bus.dBus_rsp_data : bus.iBus_rsp_payload_inst, rdata);
        step();
    endtask

    // Aligned dBus load acknowledged one cycle after the request.
    task automatic dLoad(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] expAddr,
                         input logic [3:0] expMask, input logic [31:0] rdata, input logic err,
                         input string tag);
        bus.dBus_cmd_valid           = 1'b1;
        bus.dBus_cmd_payload_wr      = 1'b0;
        bus.dBus_cmd_payload_address = addr;
        bus.dBus_cmd_payload_size    = size;
        settle();
        check($sformatf("%s dReady", tag), bus.dBus_cmd_ready, 1);
        step();
        bus.dBus_cmd_valid = 1'b0;
        check($sformatf("%s mem_we", tag), bus.mem_we, 0);
        check($sformatf("%s mem_addr", tag), bus.mem_addr, expAddr);
        check($sformatf("%s mem_wmask", tag), bus.mem_wmask, {28'd0, expMask});
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rdata;
        bus.mem_err   = err;
        step();
        bus.mem_ack = 1'b0;
        bus.mem_err = 1'b0;
        check($sformatf("%s dRsp", tag), bus.dBus_rsp_ready, 1);
        check($sformatf("%s data", tag), bus.dBus_rsp_data, rdata);
        check($sformatf("%s error", tag), bus.dBus_rsp_error, err);
        step();
        check($sformatf("%s dRsp pulse", tag), bus.dBus_rsp_ready, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset                        = 1'b1;
        bus.iBus_cmd_valid           = 1'b1;
        bus.iBus_cmd_payload_pc      = 32'h0;
        bus.dBus_cmd_valid           = 1'b0;
        bus.dBus_cmd_payload_wr      = 1'b0;
        bus.dBus_cmd_payload_address = 32'h0;
        bus.dBus_cmd_payload_data    = 32'h0;
        bus.dBus_cmd_payload_size    = 2'd2;
        bus.mem_ack                  = 1'b0;
        bus.mem_rdata                = 32'h0;
        bus.mem_err                  = 1'b0;

        // Reset held: no grant even with a valid fetch.
        step();
        step();
        check("reset iReady", bus.iBus_cmd_ready, 0);
        check("reset mem_req", bus.mem_req, 0);
        bus.iBus_cmd_valid = 1'b0;
        reset = 1'b0;
        step();
        check("reset mem_wmask", bus.mem_wmask, 0);
        check("reset mem_addr", bus.mem_addr, 0);
        check("reset iRsp", bus.iBus_rsp_valid, 0);
        check("reset dRsp", bus.dBus_rsp_ready, 0);
        check("reset iErr", bus.iBus_rsp_payload_error, 0);
        check("reset dErr", bus.dBus_rsp_error, 0);

        // Fetch with a one-cycle ack: response two cycles after accept.
        bus.iBus_cmd_valid      = 1'b1;
        bus.iBus_cmd_payload_pc = 32'h8000_0008;
        settle();
        check("fetch iReady", bus.iBus_cmd_ready, 1);
        check("fetch dReady", bus.dBus_cmd_ready, 0);
        step();
        check("fetch busy iReady", bus.iBus_cmd_ready, 0);
        bus.iBus_cmd_valid = 1'b0;
        check("fetch mem_req", bus.mem_req, 1);
        check("fetch mem_we", bus.mem_we, 0);
        check("fetch mem_addr", bus.mem_addr, 32'h8000_0008);
        check("fetch mem_wmask", bus.mem_wmask, 32'hF);
        check("fetch no early rsp", bus.iBus_rsp_valid, 0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h0020_81b3;
        step();
        bus.mem_ack = 1'b0;
        check("fetch req drop", bus.mem_req, 0);
        check("fetch iRsp", bus.iBus_rsp_valid, 1);
        check("fetch inst", bus.iBus_rsp_payload_inst, 32'h0020_81b3);
        check("fetch err", bus.iBus_rsp_payload_error, 0);
        step();
        check("fetch iRsp pulse", bus.iBus_rsp_valid, 0);
        check("fetch inst hold", bus.iBus_rsp_payload_inst, 32'h0020_81b3);

        // Fresh reset restores last grant = D, so conflicts go I, D, I.
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.iBus_cmd_valid           = 1'b1;
        bus.iBus_cmd_payload_pc      = 32'h10;
        bus.dBus_cmd_valid           = 1'b1;
        bus.dBus_cmd_payload_wr      = 1'b0;
        bus.dBus_cmd_payload_address = 32'h20;
        bus.dBus_cmd_payload_size    = 2'd2;
        conflictRound(1'b0, 32'h0000_1001, "rr1");
        conflictRound(1'b1, 32'h0000_1002, "rr2");
        conflictRound(1'b0, 32'h0000_1003, "rr3");
        bus.iBus_cmd_valid = 1'b0;
        bus.dBus_cmd_valid = 1'b0;

        // Byte store at 0x103: top lane only, no response.
        bus.dBus_cmd_valid           = 1'b1;
        bus.dBus_cmd_payload_wr      = 1'b1;
        bus.dBus_cmd_payload_address = 32'h103;
        bus.dBus_cmd_payload_data    = 32'hAAAA_AAAA;
        bus.dBus_cmd_payload_size    = 2'd0;
        settle();
        check("sb dReady", bus.dBus_cmd_ready, 1);
        step();
        bus.dBus_cmd_valid = 1'b0;
        check("sb mem_req", bus.mem_req, 1);
        check("sb mem_we", bus.mem_we, 1);
        check("sb mem_addr", bus.mem_addr, 32'h100);
        check("sb mem_wmask", bus.mem_wmask, 32'h8);
        check("sb mem_wdata", bus.mem_wdata, 32'hAAAA_AAAA);
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        check("sb req drop", bus.mem_req, 0);
        check("sb no dRsp", bus.dBus_rsp_ready, 0);
        step();
        check("sb no dRsp later", bus.dBus_rsp_ready, 0);

        // Half store at 0x102: upper half lanes.
        bus.dBus_cmd_valid           = 1'b1;
        bus.dBus_cmd_payload_address = 32'h102;
        bus.dBus_cmd_payload_data    = 32'h5555_5555;
        bus.dBus_cmd_payload_size    = 2'd1;
        step();
        bus.dBus_cmd_valid = 1'b0;
        check("sh mem_wmask", bus.mem_wmask, 32'hC);
        check("sh mem_addr", bus.mem_addr, 32'h100);
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        check("sh no dRsp", bus.dBus_rsp_ready, 0);
        step();

        dLoad(32'h0A6, 2'd1, 32'h0A4, 4'b1100, 32'h1234_5678, 1'b1, "lh err");
        dLoad(32'h104, 2'd2, 32'h104, 4'b1111, 32'h0BAD_F00D, 1'b0, "lw ok");

        // Misaligned word load: error response with no memory access.
        bus.dBus_cmd_valid           = 1'b1;
        bus.dBus_cmd_payload_wr      = 1'b0;
        bus.dBus_cmd_payload_address = 32'h102;
        bus.dBus_cmd_payload_size    = 2'd2;
        settle();
        check("mis ld dReady", bus.dBus_cmd_ready, 1);
        step();
        bus.dBus_cmd_valid = 1'b0;
        check("mis ld mem_req", bus.mem_req, 0);
        check("mis ld dRsp", bus.dBus_rsp_ready, 1);
        check("mis ld err", bus.dBus_rsp_error, 1);
        step();
        check("mis ld dRsp pulse", bus.dBus_rsp_ready, 0);
        check("mis ld mem_req later", bus.mem_req, 0);
        step();

        // Illegal-size store is dropped and the arbiter is IDLE the next cycle.
        bus.dBus_cmd_valid           = 1'b1;
        bus.dBus_cmd_payload_wr      = 1'b1;
        bus.dBus_cmd_payload_address = 32'h200;
        bus.dBus_cmd_payload_size    = 2'd3;
        step();
        check("mis st dReady again", bus.dBus_cmd_ready, 1);
        check("mis st mem_req", bus.mem_req, 0);
        check("mis st no dRsp", bus.dBus_rsp_ready, 0);
        bus.dBus_cmd_valid = 1'b0;
        step();
        check("mis st mem_req later", bus.mem_req, 0);

        // Ack arriving on the limit cycle beats the timeout.
        bus.iBus_cmd_valid      = 1'b1;
        bus.iBus_cmd_payload_pc = 32'h44;
        step();
        bus.iBus_cmd_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            check($sformatf("limit req c%0d", i), bus.mem_req, 1);
            step();
        end
        check("limit req c4", bus.mem_req, 1);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hCAFE_F00D;
        step();
        bus.mem_ack = 1'b0;
        check("limit iRsp", bus.iBus_rsp_valid, 1);
        check("limit err", bus.iBus_rsp_payload_error, 0);
        check("limit inst", bus.iBus_rsp_payload_inst, 32'hCAFE_F00D);
        check("limit req drop", bus.mem_req, 0);
        step();

        // No ack at all: mem_req high exactly 4 cycles, then an error response.
        bus.iBus_cmd_valid      = 1'b1;
        bus.iBus_cmd_payload_pc = 32'h40;
        step();
        bus.iBus_cmd_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("tmo req c%0d", i), bus.mem_req, 1);
            step();
        end
        check("tmo req drop", bus.mem_req, 0);
        check("tmo iRsp", bus.iBus_rsp_valid, 1);
        check("tmo err", bus.iBus_rsp_payload_error, 1);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hDEAD_BEEF;
        step();
        check("late ack iRsp", bus.iBus_rsp_valid, 0);
        check("late ack mem_req", bus.mem_req, 0);
        step();
        bus.mem_ack = 1'b0;
        check("idle ack iRsp", bus.iBus_rsp_valid, 0);
        check("idle ack mem_req", bus.mem_req, 0);

        // Reset while BUSY discards the fetch silently.
        bus.iBus_cmd_valid      = 1'b1;
        bus.iBus_cmd_payload_pc = 32'h80;
        step();
        bus.iBus_cmd_valid = 1'b0;
        check("mid rst req", bus.mem_req, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid rst mem_req", bus.mem_req, 0);
        check("mid rst iRsp", bus.iBus_rsp_valid, 0);
        check("mid rst mem_addr", bus.mem_addr, 0);
        check("mid rst mem_wmask", bus.mem_wmask, 0);
        check("mid rst iErr", bus.iBus_rsp_payload_error, 0);
        check("mid rst dErr", bus.dBus_rsp_error, 0);
        step();
        check("mid rst no iRsp", bus.iBus_rsp_valid, 0);

        bus.iBus_cmd_valid      = 1'b1;
        bus.iBus_cmd_payload_pc = 32'h8000_0010;
        settle();
        check("post rst iReady", bus.iBus_cmd_ready, 1);
        step();
        bus.iBus_cmd_valid = 1'b0;
        check("post rst mem_addr", bus.mem_addr, 32'h8000_0010);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h0000_0013;
        step();
        bus.mem_ack = 1'b0;
        check("post rst iRsp", bus.iBus_rsp_valid, 1);
        check("post rst inst", bus.iBus_rsp_payload_inst, 32'h0000_0013);
        check("post rst err", bus.iBus_rsp_payload_error, 0);
        step();
        check("post rst iRsp pulse", bus.iBus_rsp_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
